// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl
// Sink for the FIFO drain stage. Writes each strobed word into a single-port
// SRAM at base + word count, modulo 2**aw. It runs one capture window of
// `length` words, either one-shot or circular, and reports done, wrap and
// overflow status. All outputs are registered, so a strobe becomes an SRAM
// write exactly one cycle later.

module sram_write_ctrl #(
    parameter int dw = 32,
    parameter int aw = 10
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          cmd_start,
    input  logic          cmd_abort,
    input  logic [aw-1:0] base_addr,
    input  logic [aw-1:0] length,
    input  logic          wrap_en,
    input  logic          data_valid,
    input  logic [dw-1:0] data_in,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [aw-1:0] sram_addr,
    output logic [dw-1:0] sram_wdata,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic          overflow,
    output logic [aw-1:0] word_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] base_q, base_d;
    logic [aw-1:0] len_q, len_d;
    logic          wrap_mode_q, wrap_mode_d;
    logic [aw-1:0] count_d;
    logic [aw-1:0] addr_d;
    logic [dw-1:0] wdata_d;
    logic          we_d, done_d, wrap_d, ovf_d;
    logic [aw-1:0] last_idx;
    logic          arm;

    // Index of the final word of a pass; a zero length underflows to all-ones,
    // which is exactly the last index of a full 2**aw-word buffer.
    assign last_idx = len_q - aw'(1);

    // A start only arms from IDLE or DONE, and an abort in the same cycle wins.
    assign arm = cmd_start && !cmd_abort && (state_q != S_ACTIVE);

    assign busy = (state_q == S_ACTIVE);

    // Next-state, next-count and next-write decode.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        wrap_mode_d = wrap_mode_q;
        count_d     = word_count;
        ovf_d       = overflow;
        we_d        = 1'b0;
        addr_d      = sram_addr;
        wdata_d     = sram_wdata;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        if (arm) begin
            state_d     = S_ACTIVE;
            base_d      = base_addr;
            len_d       = length;
            wrap_mode_d = wrap_en;
            count_d     = '0;
            ovf_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Strobes with no armed window are ignored.
                end
                S_ACTIVE: begin
                    if (cmd_abort) begin
                        // The strobe in an abort cycle is dropped; count is kept for readout.
                        state_d = S_IDLE;
                    end else if (data_valid) begin
                        we_d    = 1'b1;
                        addr_d  = base_q + word_count;
                        wdata_d = data_in;
                        if (word_count == last_idx) begin
                            if (wrap_mode_q) begin
                                count_d = '0;
                                wrap_d  = 1'b1;
                            end else begin
                                count_d = word_count + aw'(1);
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end else begin
                            count_d = word_count + aw'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (cmd_abort) begin
                        state_d = S_IDLE;
                    end else if (data_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; reset clears everything, including the latched window.
    always_ff @(posedge wb_clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values regardless of statement order.
        if (wb_rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            wrap_mode_q <= 1'b0;
            word_count  <= '0;
            overflow    <= 1'b0;
            sram_ce     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            done        <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            wrap_mode_q <= wrap_mode_d;
            word_count  <= count_d;
            overflow    <= ovf_d;
            sram_ce     <= we_d;
            sram_we     <= we_d;
            sram_addr   <= addr_d;
            sram_wdata  <= wdata_d;
            done        <= done_d;
            wrap        <= wrap_d;
        end
    end

endmodule

// File: tb/tb_sram_write_ctrl.sv
// tb_sram_write_ctrl
// Directed scenarios plus a randomized run, every cycle compared against a
// behavioural model of the capture window. A second small (aw=4) instance
// covers the full-buffer length-zero window.

module tb_sram_write_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int OW    = 2 + AW + DW + 4 + AW;
    localparam int DW4   = 8;
    localparam int AW4   = 4;

    logic          wb_clk, wb_rst;
    logic          cmd_start, cmd_abort, wrap_en, data_valid;
    logic [AW-1:0] base_addr, length;
    logic [DW-1:0] data_in;
    logic          sram_ce, sram_we, busy, done, wrap, overflow;
    logic [AW-1:0] sram_addr, word_count;
    logic [DW-1:0] sram_wdata;

    logic           start4, abort4, wrapen4, valid4;
    logic [AW4-1:0] base4, len4;
    logic [DW4-1:0] data4;
    logic           ce4, we4, busy4, done4, wrap4, ovf4;
    logic [AW4-1:0] addr4, cnt4;
    logic [DW4-1:0] wdata4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model: mode 0 idle, 1 capturing, 2 finished.
    int            m_mode, m_base, m_len, m_cnt;
    bit            m_circ, m_ovf;
    bit            e_we, e_done, e_wrap;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    sram_write_ctrl #(.dw(DW), .aw(AW)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .base_addr(base_addr), .length(length), .wrap_en(wrap_en),
        .data_valid(data_valid), .data_in(data_in),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .busy(busy), .done(done), .wrap(wrap), .overflow(overflow), .word_count(word_count)
    );

    sram_write_ctrl #(.dw(DW4), .aw(AW4)) dut4 (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_start(start4), .cmd_abort(abort4),
        .base_addr(base4), .length(len4), .wrap_en(wrapen4),
        .data_valid(valid4), .data_in(data4),
        .sram_ce(ce4), .sram_we(we4), .sram_addr(addr4), .sram_wdata(wdata4),
        .busy(busy4), .done(done4), .wrap(wrap4), .overflow(ovf4), .word_count(cnt4)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    function automatic logic [OW-1:0] obs_vec();
        return {sram_ce, sram_we, sram_addr, sram_wdata, busy, done, wrap, overflow, word_count};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        return {e_we, e_we, e_addr, e_wdata, (m_mode == 1), e_done, e_wrap, m_ovf, AW'(m_cnt % DEPTH)};
    endfunction

    // Drive one cycle of inputs, advance the model, and sample 1 ns after the edge.
    task automatic tick(input bit rst, input bit start, input bit abort, input bit valid,
                        input logic [DW-1:0] data, input logic [AW-1:0] base,
                        input logic [AW-1:0] len, input bit wr);
        wb_rst = rst; cmd_start = start; cmd_abort = abort; data_valid = valid;
        data_in = data; base_addr = base; length = len; wrap_en = wr;
        e_we = 0; e_done = 0; e_wrap = 0;
        if (rst) begin
            m_mode = 0; m_base = 0; m_len = 0; m_circ = 0; m_cnt = 0; m_ovf = 0;
            e_addr = '0; e_wdata = '0;
        end else if (m_mode != 1 && start && !abort) begin
            m_mode = 1; m_base = int'(base); m_len = (len == 0) ? DEPTH : int'(len);
            m_circ = wr; m_cnt = 0; m_ovf = 0;
        end else if (abort) begin
            m_mode = 0;
        end else if (m_mode == 1 && valid) begin
            e_we = 1; e_addr = AW'((m_base + m_cnt) % DEPTH); e_wdata = data;
            m_cnt++;
            if (m_cnt == m_len) begin
                if (m_circ) begin m_cnt = 0; e_wrap = 1; end
                else begin m_mode = 2; e_done = 1; end
            end
        end else if (m_mode == 2 && valid) begin
            m_ovf = 1;
        end
        @(posedge wb_clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, '0, '0, '0, 0);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, '0, '0, '0, 0);
        tick(1, 0, 0, 1, 32'hDEAD_BEEF, 10'h123, 10'd5, 1);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h required 0", obs_vec());
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, $urandom, '0, '0, 0);
            n_checks++;
            if (sram_we !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
                n_errors++; $display("FAIL idle_strobe_ignored %0d: we=%b busy=%b ovf=%b required 0", i, sram_we, busy, overflow);
            end
        end
    endtask

    task automatic test_oneshot();
        tick(0, 1, 0, 0, '0, 10'h010, 10'd4, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1, $urandom, '0, '0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL oneshot_cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            n_checks++;
            if (sram_we !== 1'b1 || sram_addr !== AW'(16 + i) || sram_wdata !== data_in) begin
                n_errors++; $display("FAIL oneshot_write %0d: we=%b addr=%h data=%h required 1 %h %h", i, sram_we, sram_addr, sram_wdata, AW'(16 + i), data_in);
            end
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || word_count !== 10'd4) begin
            n_errors++; $display("FAIL oneshot_end: done=%b busy=%b count=%0d required 1 0 4", done, busy, word_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 1, $urandom, '0, '0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL overflow_cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            n_checks++;
            if (sram_we !== 1'b0 || overflow !== 1'b1 || done !== 1'b0) begin
                n_errors++; $display("FAIL overflow_flag %0d: we=%b ovf=%b done=%b required 0 1 0", i, sram_we, overflow, done);
            end
        end
        tick(0, 1, 0, 0, '0, 10'h010, 10'd4, 0);
        n_checks++;
        if (overflow !== 1'b0 || busy !== 1'b1 || word_count !== 10'd0) begin
            n_errors++; $display("FAIL overflow_clear: ovf=%b busy=%b count=%0d required 0 1 0", overflow, busy, word_count);
        end
        tick(0, 0, 1, 0, '0, '0, '0, 0);
    endtask

    task automatic test_circular();
        logic [AW-1:0] addrs [9];
        addrs = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h3FE};
        tick(0, 1, 0, 0, '0, 10'h3FE, 10'd4, 1);
        for (int i = 0; i < 9; i++) begin
            tick(0, 0, 0, 1, $urandom, '0, '0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL circular_cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            n_checks++;
            if (sram_we !== 1'b1 || sram_addr !== addrs[i] || wrap !== (i == 3 || i == 7) || busy !== 1'b1) begin
                n_errors++; $display("FAIL circular_addr %0d: we=%b addr=%h wrap=%b busy=%b required 1 %h %b 1", i, sram_we, sram_addr, wrap, busy, addrs[i], (i == 3 || i == 7));
            end
        end
        tick(0, 0, 1, 0, '0, '0, '0, 0);
    endtask

    task automatic test_abort();
        int writes = 0;
        tick(0, 1, 0, 0, '0, AW'($urandom), 10'd8, 0);
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, (i == 6), (i % 3 == 0), $urandom, '0, '0, 0);
            writes += int'(sram_we);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL abort_cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
        n_checks++;
        if (writes != 2 || busy !== 1'b0 || word_count !== 10'd2 || sram_we !== 1'b0) begin
            n_errors++; $display("FAIL abort_end: writes=%0d busy=%b count=%0d we=%b required 2 0 2 0", writes, busy, word_count, sram_we);
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 1, 0, 0, '0, 10'h200, 10'd6, 1);
        tick(0, 0, 0, 1, $urandom, '0, '0, 0);
        tick(0, 0, 0, 1, $urandom, '0, '0, 0);
        tick(1, 0, 0, 1, $urandom, '0, '0, 0);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++; $display("FAIL reset_mid: got %h required 0", obs_vec());
        end
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 1, $urandom, '0, '0, 0);
            n_checks++;
            if (sram_we !== 1'b0 || busy !== 1'b0) begin
                n_errors++; $display("FAIL reset_mid_idle %0d: we=%b busy=%b required 0 0", i, sram_we, busy);
            end
        end
    endtask

    task automatic test_random();
        bit            rst, start, abort, valid, wr;
        logic [AW-1:0] base, len;
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 99) < 6);
            abort = ($urandom_range(0, 99) < 3);
            valid = ($urandom_range(0, 99) < 65);
            wr    = 1'($urandom_range(0, 1));
            base  = ($urandom_range(0, 1) == 1) ? AW'(10'h3F8 + $urandom_range(0, 7)) : AW'($urandom);
            len   = AW'($urandom_range(0, 9));
            if (m_mode == 2 && start) valid = 0;
            tick(rst, start, abort, valid, $urandom, base, len, wr);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL random_cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_len0();
        int writes = 0;
        tick(1, 0, 0, 0, '0, '0, '0, 0);
        idle();
        start4 = 1; base4 = 4'hA; len4 = '0; wrapen4 = 0;
        @(posedge wb_clk); #1;
        start4 = 0;
        n_checks++;
        if (busy4 !== 1'b1 || we4 !== 1'b0) begin
            n_errors++; $display("FAIL len0_arm: busy=%b we=%b required 1 0", busy4, we4);
        end
        for (int i = 0; i < 16; i++) begin
            valid4 = 1; data4 = DW4'(i + 8'h40);
            @(posedge wb_clk); #1;
            writes += int'(we4);
            n_checks++;
            if (we4 !== 1'b1 || addr4 !== AW4'(10 + i) || wdata4 !== DW4'(i + 8'h40) || done4 !== (i == 15)) begin
                n_errors++; $display("FAIL len0_write %0d: we=%b addr=%h data=%h done=%b required 1 %h %h %b", i, we4, addr4, wdata4, done4, AW4'(10 + i), DW4'(i + 8'h40), (i == 15));
            end
        end
        valid4 = 0;
        @(posedge wb_clk); #1;
        n_checks++;
        if (writes != 16 || busy4 !== 1'b0 || we4 !== 1'b0 || done4 !== 1'b0) begin
            n_errors++; $display("FAIL len0_end: writes=%0d busy=%b we=%b done=%b required 16 0 0 0", writes, busy4, we4, done4);
        end
    endtask

    initial begin
        start4 = 0; abort4 = 0; wrapen4 = 0; valid4 = 0; base4 = '0; len4 = '0; data4 = '0;
        test_reset();
        test_oneshot();
        test_overflow();
        test_circular();
        test_abort();
        test_reset_mid();
        test_random();
        test_len0();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
